team_06_i2c_master: RTL and testbench

- Write-only I2C master that carries LCD command bytes from team_06_displayFSM to the PCF8574-style LCD backpack.
- Accepts a byte stream via trans/lcdOut and returns i2cState, ready and commsError to the display FSM.
- Drives open-drain SCL/SDA. Each transaction is START, address+W, N data bytes, STOP.

---
 rtl/team_06_i2c_master.sv | 253 +++++++++++++++++++++++++
 tb/tb_team_06_i2c_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/team_06_i2c_master.sv
// ---------------------------------------------------------------------------
// team_06_i2c_master
//
// Write-only I2C master that carries LCD command bytes from the display FSM
// to a PCF8574-style LCD backpack. Each transaction is START, {DEV_ADDR,W},
// N data bytes, STOP. The bus is driven open-drain only: an *_oe output of 1
// pulls the line low and 0 releases it. A line is never driven high.
//
// Bit timing: every bit spans 4 quarters of QDIV = CLK_DIV/4 clocks.
//   q0: SCL low, SDA set   q1,q2: SCL released   q3: SCL low
//   SDA is sampled at the end of q1.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   trans      in   transaction request / continue from the display FSM
//   data_in    in   byte to send (display FSM lcdOut)
//   sda_in     in   sampled SDA pad
//   scl_in     in   sampled SCL pad (only used for clock stretching)
//   sda_oe     out  1 = pull SDA low
//   scl_oe     out  1 = pull SCL low
//   i2cState   out  BEGINS=0 SEND=1 ACK=2 ENDS=3 OFF=4
//   ready      out  one-cycle pulse asking for the next byte
//   commsError out  one-cycle pulse on NACK
//
// Optional feature: define TEAM_06_I2C_CLK_STRETCH_EN to let a slave stretch
// SCL. While the master has SCL released and scl_in reads 0, the quarter
// counter holds at 0. Without the macro scl_in is ignored.
//
// CLK_DIV must be a multiple of 4 and at least 16.
// ---------------------------------------------------------------------------
module team_06_i2c_master #(
    parameter int         CLK_DIV  = 100,
    parameter logic [6:0] DEV_ADDR = 7'h27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trans,
    input  logic [7:0] data_in,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic [2:0] i2cState,
    output logic       ready,
    output logic       commsError
);

    localparam int QDIV = CLK_DIV / 4;
    localparam int QW   = (QDIV > 1) ? $clog2(QDIV) : 1;

    typedef enum logic [2:0] {
        BEGINS = 3'd0,
        SEND   = 3'd1,
        ACK    = 3'd2,
        ENDS   = 3'd3,
        OFF    = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [QW-1:0] qcnt;
    logic [1:0]    qph, qph_n;          // quarter index inside the current bit / phase
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    pending, pending_n;  // first data byte, held while the address goes out
    logic          addr_done, addr_done_n;
    logic          nack, nack_n;
    logic          waiting, waiting_n;  // post-ready pause inside ACK
    logic          wcnt, wcnt_n;
    logic          sda_oe_n, scl_oe_n;
    logic          qtick;
    logic          stall;

`ifdef TEAM_06_I2C_CLK_STRETCH_EN
    // Slave holds SCL low while we have released it: freeze the timebase.
    assign stall = (state != OFF) && !scl_oe && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign stall = 1'b0;
`endif

    assign qtick = (state != OFF) && !stall && (qcnt == QW'(QDIV - 1));

    // Quarter counter; parked at 0 in OFF so BEGINS starts on a fresh quarter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            qcnt <= '0;
        else if (state == OFF || stall || qtick)
            qcnt <= '0;
        else
            qcnt <= qcnt + QW'(1);
    end

    // Line levels for the quarter being entered. Returns {scl_oe, sda_oe}.
    function automatic logic [1:0] lines(input state_t st, input logic [1:0] ph,
                                         input logic b, input logic w);
        case (st)
            BEGINS:  lines = {ph != 2'd0, 1'b1};                      // START, then SCL low
            SEND:    lines = {ph == 2'd0 || ph == 2'd3, ~b};
            ACK:     lines = {w || ph == 2'd0 || ph == 2'd3, 1'b0};   // SDA released for the slave
            ENDS:    lines = {ph == 2'd0, ph != 2'd2};                 // SDA rises last: STOP
            default: lines = 2'b00;
        endcase
    endfunction

    always_comb begin
        state_n     = state;
        qph_n       = qph;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        pending_n   = pending;
        addr_done_n = addr_done;
        nack_n      = nack;
        waiting_n   = waiting;
        wcnt_n      = wcnt;
        ready       = 1'b0;
        commsError  = 1'b0;

        case (state)
            OFF: begin
                // Start is taken on any clock, not gated by qtick.
                if (trans) begin
                    pending_n   = data_in;
                    shift_n     = {DEV_ADDR, 1'b0};
                    addr_done_n = 1'b0;
                    nack_n      = 1'b0;
                    waiting_n   = 1'b0;
                    wcnt_n      = 1'b0;
                    qph_n       = 2'd0;
                    bit_cnt_n   = 3'd7;
                    state_n     = BEGINS;
                end
            end

            BEGINS: begin
                if (qtick) begin
                    if (qph == 2'd0) begin
                        qph_n = 2'd1;
                    end else begin
                        qph_n     = 2'd0;
                        bit_cnt_n = 3'd7;
                        state_n   = SEND;
                    end
                end
            end

            SEND: begin
                if (qtick) begin
                    qph_n = qph + 2'd1;
                    if (qph == 2'd3) begin
                        if (bit_cnt == 3'd0) begin
                            state_n = ACK;
                        end else begin
                            bit_cnt_n = bit_cnt - 3'd1;
                            shift_n   = {shift[6:0], 1'b0};
                        end
                    end
                end
            end

            ACK: begin
                if (qtick) begin
                    if (waiting) begin
                        // Two quarters give the display FSM time to update
                        // lcdOut/trans after ready.
                        wcnt_n = 1'b1;
                        if (wcnt) begin
                            waiting_n = 1'b0;
                            wcnt_n    = 1'b0;
                            qph_n     = 2'd0;
                            if (trans) begin
                                pending_n = data_in;
                                shift_n   = data_in;
                                bit_cnt_n = 3'd7;
                                state_n   = SEND;
                            end else begin
                                state_n = ENDS;
                            end
                        end
                    end else begin
                        qph_n = qph + 2'd1;
                        if (qph == 2'd1)
                            nack_n = sda_in;
                        // The ACK slot is always completed so SCL is low
                        // before SDA moves for the next phase.
                        if (qph == 2'd3) begin
                            if (nack) begin
                                commsError = 1'b1;
                                state_n    = ENDS;
                            end else if (!addr_done) begin
                                addr_done_n = 1'b1;
                                shift_n     = pending;
                                bit_cnt_n   = 3'd7;
                                state_n     = SEND;
                            end else begin
                                ready     = 1'b1;
                                waiting_n = 1'b1;
                                wcnt_n    = 1'b0;
                            end
                        end
                    end
                end
            end

            ENDS: begin
                if (qtick) begin
                    if (qph == 2'd2) begin
                        qph_n   = 2'd0;
                        state_n = OFF;
                    end else begin
                        qph_n = qph + 2'd1;
                    end
                end
            end

            default: state_n = OFF;
        endcase

        {scl_oe_n, sda_oe_n} = lines(state_n, qph_n, shift_n[7], waiting_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= OFF;
            qph       <= 2'd0;
            bit_cnt   <= 3'd0;
            shift     <= 8'd0;
            pending   <= 8'd0;
            addr_done <= 1'b0;
            nack      <= 1'b0;
            waiting   <= 1'b0;
            wcnt      <= 1'b0;
            sda_oe    <= 1'b0;
            scl_oe    <= 1'b0;
        end else begin
            state     <= state_n;
            qph       <= qph_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            pending   <= pending_n;
            addr_done <= addr_done_n;
            nack      <= nack_n;
            waiting   <= waiting_n;
            wcnt      <= wcnt_n;
            sda_oe    <= sda_oe_n;
            scl_oe    <= scl_oe_n;
        end
    end

    assign i2cState = state;

endmodule

// File: tb/tb_team_06_i2c_master.sv
// ---------------------------------------------------------------------------
// Bench for team_06_i2c_master. A CLK_DIV=16 instance talks to a bus monitor
// and ACKing slave model; a CLK_DIV=100 instance is used for SCL timing.
// ---------------------------------------------------------------------------
module tb_team_06_i2c_master;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       trans;
    logic [7:0] data_in;
    logic       sda_in, scl_in, sda_oe, scl_oe, ready, commsError;
    logic [2:0] i2cState;
    logic       slave_pull = 1'b0;
    logic       stretch    = 1'b0;

    assign sda_in = ~(sda_oe | slave_pull);
    assign scl_in = ~(scl_oe | stretch);

    team_06_i2c_master #(.CLK_DIV(16), .DEV_ADDR(7'h27)) dut (
        .clk(clk), .rst(rst), .trans(trans), .data_in(data_in),
        .sda_in(sda_in), .scl_in(scl_in), .sda_oe(sda_oe), .scl_oe(scl_oe),
        .i2cState(i2cState), .ready(ready), .commsError(commsError)
    );

    logic       trans2;
    logic [7:0] data2;
    logic       sda_oe2, scl_oe2, ready2, err2;
    logic [2:0] st2;

    team_06_i2c_master #(.CLK_DIV(100), .DEV_ADDR(7'h27)) dut_slow (
        .clk(clk), .rst(rst), .trans(trans2), .data_in(data2),
        .sda_in(1'b0), .scl_in(~scl_oe2), .sda_oe(sda_oe2), .scl_oe(scl_oe2),
        .i2cState(st2), .ready(ready2), .commsError(err2)
    );

`ifdef TEAM_06_I2C_CLK_STRETCH_EN
    localparam int EXT = 50;
`else
    localparam int EXT = 0;
`endif

    int applied = 0;
    int miscmp  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0d (o%0o) expected %0d (o%0o)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- bus monitor + slave ----------------
    int         cyc_g = 0, nbit = 0, starts = 0, stops = 0, viol = 0, nack_abs = -1;
    int         start_t = 0, stop_t = 0;
    logic [7:0] sh = 8'd0;
    logic [7:0] bytes_q[$];
    logic       scl_p = 1'b1, sda_p = 1'b1;

    always @(negedge clk) begin
        logic scl_b, sda_b;
        scl_b = ~scl_oe;
        sda_b = sda_in;
        cyc_g++;
        if ((ready && commsError) || ((ready || commsError) && i2cState != 3'd2))
            viol++;
        if (rst) begin
            nbit       = 0;
            slave_pull = 1'b0;
        end else begin
            if (scl_p && scl_b && sda_p && !sda_b) begin
                starts++; start_t = cyc_g; nbit = 0;
            end
            if (scl_p && scl_b && !sda_p && sda_b) begin
                stops++; stop_t = cyc_g;
            end
            if (!scl_p && scl_b) begin
                if (nbit < 8) sh = {sh[6:0], sda_b};
                nbit++;
                if (nbit == 9) begin
                    bytes_q.push_back(sh);
                    nbit = 0;
                end
            end
            // Slave drives the ACK slot after the 8th bit unless told to NACK.
            if (scl_p && !scl_b)
                slave_pull = (nbit == 8) && (bytes_q.size() != nack_abs);
        end
        scl_p = scl_b;
        sda_p = sda_b;
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0][7:0] b;
        int              n, nack_at, stretch_rel;
        int              exp_rdy, exp_err, exp_nbytes, exp_dur;
        logic [63:0]     exp_seq;
    } vec_t;

    function automatic vec_t mkv(input logic [23:0] b, input int n, input int na, input int sr,
                                 input int er, input int ee, input int nb, input int d,
                                 input logic [63:0] sq);
        vec_t v;
        v.b = b; v.n = n; v.nack_at = na; v.stretch_rel = sr;
        v.exp_rdy = er; v.exp_err = ee; v.exp_nbytes = nb; v.exp_dur = d; v.exp_seq = sq;
        return v;
    endfunction

    vec_t tbl[5];

    task automatic run_vec(input vec_t v, input int idx);
        int          base, s0, p0, v0, cyc, k, rel, left, err_cyc, off_cyc;
        int          nrdy, nerr;
        bit          done, left_off;
        logic [63:0] seq;
        logic [2:0]  pst;
        logic        pscl;
        logic [7:0]  eb;
        string       tag;
        tag  = $sformatf("v%0d", idx);
        base = bytes_q.size(); s0 = starts; p0 = stops; v0 = viol;
        nack_abs = (v.nack_at < 0) ? -1 : base + v.nack_at;
        cyc = 0; k = 1; rel = 0; left = 0; err_cyc = 0; off_cyc = 0;
        nrdy = 0; nerr = 0; done = 0; left_off = 0;
        @(negedge clk);
        data_in = v.b[0];
        trans   = 1'b1;
        seq  = 64'(i2cState);
        pst  = i2cState;
        pscl = scl_oe;
        while (cyc < 5000 && !done) begin
            @(negedge clk);
            cyc++;
            if (i2cState != pst) begin
                seq = {seq[60:0], i2cState};
                pst = i2cState;
            end
            if (left > 0) begin
                left--;
                if (left == 0) stretch = 1'b0;
            end
            if (pscl && !scl_oe) begin
                rel++;
                if (v.stretch_rel != 0 && rel == v.stretch_rel) begin
                    stretch = 1'b1; left = 50;
                end
            end
            pscl = scl_oe;
            if (i2cState != 3'd4) left_off = 1;
            else if (left_off) begin done = 1; off_cyc = cyc; end
            if (!done && commsError) begin
                nerr++; err_cyc = cyc; trans = 1'b0;
            end
            if (!done && ready) begin
                nrdy++;
                @(posedge clk); #1;
                if (k < v.n) data_in = v.b[k];
                else trans = 1'b0;
                k++;
            end
        end
        stretch = 1'b0;
        trans   = 1'b0;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_ready_pulses"}, nrdy, v.exp_rdy);
        chk({tag, "_err_pulses"}, nerr, v.exp_err);
        chk({tag, "_starts"}, starts - s0, 1);
        chk({tag, "_stops"}, stops - p0, 1);
        chk({tag, "_pulse_rules"}, viol - v0, 0);
        chk({tag, "_state_seq"}, seq, v.exp_seq);
        chk({tag, "_start_to_stop"}, stop_t - start_t,
            v.exp_dur + ((v.stretch_rel != 0) ? EXT : 0));
        chk({tag, "_nbytes"}, bytes_q.size() - base, v.exp_nbytes);
        for (int i = 0; i < v.exp_nbytes && base + i < bytes_q.size(); i++) begin
            eb = (i == 0) ? 8'h4E : v.b[i-1];
            chk($sformatf("%s_byte%0d", tag, i), bytes_q[base+i], eb);
        end
        if (v.exp_err != 0)
            chk({tag, "_nack_to_off"}, off_cyc - err_cyc, 13);
        nack_abs = -1;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_slow();
        int   rel, prev_t, bad, nint, hi_chg;
        bit   done, left_off;
        logic pscl, psda;
        rel = 0; prev_t = 0; bad = 0; nint = 0; hi_chg = 0; done = 0; left_off = 0;
        @(negedge clk);
        trans2 = 1'b1; data2 = 8'h0C;
        pscl = scl_oe2; psda = sda_oe2;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(negedge clk);
            if (!pscl && !scl_oe2 && psda != sda_oe2) hi_chg++;
            if (pscl && !scl_oe2) begin
                rel++;
                // releases 1..18: address bits, ACK, data bits, ACK (no pauses)
                if (rel >= 2 && rel <= 18) begin
                    nint++;
                    if (c - prev_t != 100) bad++;
                end
                prev_t = c;
            end
            pscl = scl_oe2; psda = sda_oe2;
            if (st2 != 3'd4) left_off = 1;
            else if (left_off) done = 1;
            if (ready2) begin
                @(posedge clk); #1;
                trans2 = 1'b0;
            end
        end
        trans2 = 1'b0;
        chk("slow_done", done, 1);
        chk("slow_period_count", nint, 17);
        chk("slow_bad_periods", bad, 0);
        chk("slow_sda_moves_scl_high", hi_chg, 2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", miscmp);
        $fatal(1);
    end

    initial begin
        int   rel;
        bit   found;
        logic pscl;
        rst = 1'b1; trans = 1'b0; data_in = 8'h00; trans2 = 1'b0; data2 = 8'h00;

        //          bytes      n  nack stretch rdy err nb dur  state sequence
        tbl[0] = mkv(24'h00000C, 1, -1, 0, 1, 0, 2, 312, 64'o40121234);
        tbl[1] = mkv(24'hEC0C2C, 3, -1, 0, 3, 0, 4, 616, 64'o401212121234);
        tbl[2] = mkv(24'h000055, 1,  0, 0, 0, 1, 1, 160, 64'o401234);
        tbl[3] = mkv(24'h000081, 2,  1, 0, 0, 1, 2, 304, 64'o40121234);
        tbl[4] = mkv(24'h00000C, 1, -1, 5, 1, 0, 2, 312, 64'o40121234);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_scl_oe", scl_oe, 0);
        chk("rst_state", i2cState, 4);
        chk("rst_ready", ready, 0);
        chk("rst_err", commsError, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_state", i2cState, 4);

        for (int i = 0; i < 5; i++)
            run_vec(tbl[i], i);

        // Reset in the middle of data bit 4 while SCL is held low.
        @(negedge clk);
        data_in = 8'hA5; trans = 1'b1;
        rel = 0; found = 0; pscl = scl_oe;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk);
            if (pscl && !scl_oe) rel++;
            pscl = scl_oe;
            if (rel == 13) found = 1;
        end
        chk("midrst_reached", found, 1);
        repeat (9) @(negedge clk);
        chk("midrst_pre_scl_low", scl_oe, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_sda_oe", sda_oe, 0);
        chk("midrst_scl_oe", scl_oe, 0);
        chk("midrst_state", i2cState, 4);
        trans = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run_vec(tbl[0], 5);

        run_slow();

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscmp);
        $finish;
    end

endmodule
